// File: rtl/jtag_vm_pkg.sv
// Shared constants for the JTAG vector master: register map, control/status
// bit positions, shift FSM encoding and IEEE 1149.1 TAP state encoding.
package jtag_vm_pkg;

  localparam logic [3:0] REG_CLKDIV   = 4'd0;
  localparam logic [3:0] REG_CTRL     = 4'd1;
  localparam logic [3:0] REG_LEN      = 4'd2;
  localparam logic [3:0] REG_TDI      = 4'd3;
  localparam logic [3:0] REG_TMS      = 4'd4;
  localparam logic [3:0] REG_TDO      = 4'd5;
  localparam logic [3:0] REG_STATUS   = 4'd6;
  localparam logic [3:0] REG_IRQ_MASK = 4'd7;
  localparam logic [3:0] REG_IRQ_STS  = 4'd8;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_TRST     = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_TMS_IDLE = 3;

  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_ERR     = 2;
  localparam int STS_TAP_LSB = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOW    = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [3:0] {
    TAP_EX2_DR    = 4'h0,
    TAP_EX1_DR    = 4'h1,
    TAP_SHIFT_DR  = 4'h2,
    TAP_PAUSE_DR  = 4'h3,
    TAP_SEL_IR    = 4'h4,
    TAP_UPD_DR    = 4'h5,
    TAP_CAP_DR    = 4'h6,
    TAP_SEL_DR    = 4'h7,
    TAP_EX2_IR    = 4'h8,
    TAP_EX1_IR    = 4'h9,
    TAP_SHIFT_IR  = 4'hA,
    TAP_PAUSE_IR  = 4'hB,
    TAP_RTI       = 4'hC,
    TAP_UPD_IR    = 4'hD,
    TAP_CAP_IR    = 4'hE,
    TAP_TLR       = 4'hF
  } tap_state_e;

endpackage

// File: rtl/jtag_vector_master_if.sv
// Wishbone classic slave bundle between the Microwatt bus and the JTAG master.
interface jtag_vector_master_if;
  logic [29:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/jtag_vector_master_tap_tracker.sv
// Shadow IEEE 1149.1 TAP controller, stepped on each TCK rise we generate.
module jtag_tap_tracker
  import jtag_vm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       trst_i,
  input  logic       tck_rise_i,
  input  logic       tms_i,
  output logic [3:0] state_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (tck_rise_i) begin
      case (state_q)
        TAP_TLR:      state_d = tms_i ? TAP_TLR    : TAP_RTI;
        TAP_RTI:      state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
        TAP_CAP_DR:   state_d = tms_i ? TAP_EX1_DR : TAP_SHIFT_DR;
        TAP_SHIFT_DR: state_d = tms_i ? TAP_EX1_DR : TAP_SHIFT_DR;
        TAP_EX1_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR: state_d = tms_i ? TAP_EX2_DR : TAP_PAUSE_DR;
        TAP_EX2_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_SHIFT_DR;
        TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_IR:   state_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
        TAP_CAP_IR:   state_d = tms_i ? TAP_EX1_IR : TAP_SHIFT_IR;
        TAP_SHIFT_IR: state_d = tms_i ? TAP_EX1_IR : TAP_SHIFT_IR;
        TAP_EX1_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR: state_d = tms_i ? TAP_EX2_IR : TAP_PAUSE_IR;
        TAP_EX2_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_SHIFT_IR;
        TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
        default:      state_d = TAP_TLR;
      endcase
    end
  end

  // TRST holds the real TAP in reset, so the shadow follows it there too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= TAP_TLR;
    else if (trst_i) state_q <= TAP_TLR;
    else             state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_vector_master.sv
// Wishbone-slave JTAG master shifting per-bit TDI/TMS vectors with TDO readback.
// Optional TAP state tracking in STATUS[11:8] when JTAG_TAP_TRACK_EN is defined.
module jtag_vector_master
  import jtag_vm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  jtag_vector_master_if.slave  wb,
  output logic                 tck_o,
  output logic                 tms_o,
  output logic                 tdi_o,
  output logic                 trst_o,
  input  logic                 tdo_i,
  output logic                 intr_o
);

  logic              sel, prev_sel_q, ack_q, wr_en, busy;
  logic [3:0]        idx;
  logic [DIV_W-1:0]  clkdiv_q, cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, eff_len, n_q, n_d, bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] tdi_q, tms_q, tdo_q, tdo_d;
  logic [DATA_W-1:0] shift_tdi_q, shift_tdi_d, shift_tms_q, shift_tms_d;
  logic [1:0]        state_q, state_d, irq_mask_q, irq_sts_q, irq_sts_d, irq_w1c;
  logic              trst_q, tms_idle_q, tck_q, tck_d, done_q, done_d, err_q, err_d;
  logic              start, go_err, abort, busy_wr_err, finish, tck_rise, half_done;
  logic [3:0]        tap_state;
  logic [31:0]       rdata;

  assign sel     = wb.wb_cyc_i & wb.wb_stb_i;
  assign idx     = wb.wb_adr_i[3:0];
  assign wr_en   = ack_q & sel & wb.wb_we_i;
  assign busy    = (state_q != ST_IDLE);
  assign eff_len = (len_q == '0 || len_q > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_q;

  assign start       = wr_en && idx == REG_CTRL && wb.wb_dat_i[CTRL_GO] && !busy;
  assign go_err      = wr_en && idx == REG_CTRL && wb.wb_dat_i[CTRL_GO] && busy;
  assign abort       = wr_en && idx == REG_CTRL && wb.wb_dat_i[CTRL_ABORT] && busy;
  assign busy_wr_err = wr_en && busy && (idx == REG_CLKDIV || idx == REG_LEN ||
                                         idx == REG_TDI || idx == REG_TMS);
  assign irq_w1c     = (wr_en && idx == REG_IRQ_STS) ? wb.wb_dat_i[1:0] : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sel_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      prev_sel_q <= sel;
      ack_q      <= sel & ~prev_sel_q;
    end
  end

  // Shift-defining registers are frozen while a transaction is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkdiv_q   <= '1;
      trst_q     <= 1'b1;
      tms_idle_q <= 1'b0;
      len_q      <= '0;
      tdi_q      <= '0;
      tms_q      <= '0;
      irq_mask_q <= '0;
    end else if (wr_en) begin
      case (idx)
        REG_CLKDIV:   if (!busy) clkdiv_q <= wb.wb_dat_i[DIV_W-1:0];
        REG_CTRL: begin
          trst_q     <= wb.wb_dat_i[CTRL_TRST];
          tms_idle_q <= wb.wb_dat_i[CTRL_TMS_IDLE];
        end
        REG_LEN:      if (!busy) len_q <= wb.wb_dat_i[LEN_W-1:0];
        REG_TDI:      if (!busy) tdi_q <= wb.wb_dat_i[DATA_W-1:0];
        REG_TMS:      if (!busy) tms_q <= wb.wb_dat_i[DATA_W-1:0];
        REG_IRQ_MASK: irq_mask_q <= wb.wb_dat_i[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    n_d         = n_q;
    shift_tdi_d = shift_tdi_q;
    shift_tms_d = shift_tms_q;
    tck_d       = tck_q;
    tdo_d       = tdo_q;
    tck_rise    = 1'b0;
    finish      = 1'b0;
    half_done   = (cnt_q == clkdiv_q);
    case (state_q)
      ST_IDLE: if (start) begin
        state_d     = ST_LOW;
        cnt_d       = '0;
        bit_idx_d   = '0;
        n_d         = eff_len;
        shift_tdi_d = tdi_q;
        shift_tms_d = tms_q;
        tdo_d       = '0;
      end
      ST_LOW: if (half_done) begin
        state_d  = ST_HIGH;
        cnt_d    = '0;
        tck_d    = 1'b1;
        tck_rise = 1'b1;
        tdo_d    = tdo_q | (DATA_W'(tdo_i) << bit_idx_q);
      end else cnt_d = cnt_q + DIV_W'(1);
      ST_HIGH: if (half_done) begin
        cnt_d = '0;
        tck_d = 1'b0;
        if (bit_idx_q == n_q - LEN_W'(1)) state_d = ST_FINISH;
        else begin
          state_d     = ST_LOW;
          bit_idx_d   = bit_idx_q + LEN_W'(1);
          shift_tdi_d = shift_tdi_q >> 1;
          shift_tms_d = shift_tms_q >> 1;
        end
      end else cnt_d = cnt_q + DIV_W'(1);
      default: begin
        state_d = ST_IDLE;
        finish  = 1'b1;
      end
    endcase
    // Abort beats anything the shifter planned for this edge.
    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      tck_d    = 1'b0;
      tdo_d    = tdo_q;
      tck_rise = 1'b0;
      finish   = 1'b0;
    end

    done_d = done_q;
    err_d  = err_q;
    if (start)  begin done_d = 1'b0; err_d = 1'b0; end
    if (finish) done_d = 1'b1;
    if (go_err || busy_wr_err || abort) err_d = 1'b1;
    irq_sts_d = (irq_sts_q & ~irq_w1c) | {busy_wr_err | abort, finish};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      n_q         <= '0;
      shift_tdi_q <= '0;
      shift_tms_q <= '0;
      tck_q       <= 1'b0;
      tdo_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_sts_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      n_q         <= n_d;
      shift_tdi_q <= shift_tdi_d;
      shift_tms_q <= shift_tms_d;
      tck_q       <= tck_d;
      tdo_q       <= tdo_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_sts_q   <= irq_sts_d;
    end
  end

`ifdef JTAG_TAP_TRACK_EN
  jtag_tap_tracker u_tap_tracker (
    .clk        (clk),
    .rst        (rst),
    .trst_i     (trst_q),
    .tck_rise_i (tck_rise),
    .tms_i      (tms_o),
    .state_o    (tap_state)
  );
`else
  logic unused_tck_rise;
  assign unused_tck_rise = tck_rise;
  assign tap_state       = 4'h0;
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      REG_CLKDIV:   rdata = 32'(clkdiv_q);
      REG_CTRL:     rdata = {28'b0, tms_idle_q, 1'b0, trst_q, 1'b0};
      REG_LEN:      rdata = 32'(len_q);
      REG_TDI:      rdata = 32'(tdi_q);
      REG_TMS:      rdata = 32'(tms_q);
      REG_TDO:      rdata = 32'(tdo_q);
      REG_STATUS:   rdata = {20'b0, tap_state, 5'b0, err_q, done_q, busy};
      REG_IRQ_MASK: rdata = {30'b0, irq_mask_q};
      REG_IRQ_STS:  rdata = {30'b0, irq_sts_q};
      default:      rdata = '0;
    endcase
  end

  logic unused_bus;
  assign unused_bus = ^{wb.wb_sel_i, wb.wb_adr_i[29:4], wb.wb_dat_i};

  assign wb.wb_dat_o   = rdata;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_stall_o = 1'b0;
  assign tck_o         = tck_q;
  assign tdi_o         = busy & shift_tdi_q[0];
  assign tms_o         = busy ? shift_tms_q[0] : tms_idle_q;
  assign trst_o        = trst_q;
  assign intr_o        = |(irq_sts_q & irq_mask_q);

endmodule
